// File: rtl/instr_fetch_pkg.sv
// Shared fetch types: PC select encoding, raw instruction word, fetch FSM states.
package Common;

    typedef logic [31:0] uint32;
    typedef uint32       raw_instr_t;

    typedef enum logic [2:0] {
        PC_PLUS_4 = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JUMP   = 3'd2,
        PC_MTVEC  = 3'd3,
        PC_MEPEC  = 3'd4
    } pc_next_t;

    typedef enum logic {
        FETCH_RUN,
        FETCH_MISALIGN
    } fetch_state_t;

    localparam uint32 FETCH_RESET_PC = 32'h0000_0000;

    function automatic logic word_misaligned(input uint32 addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus bundle: memory request/response, decoder output, redirect inputs, fault status.
interface instr_fetch_if;
  import Common::*;

  logic       mem_req_valid;
  logic       mem_req_ready;
  uint32      mem_req_addr;
  logic       mem_rsp_valid;
  uint32      mem_rsp_data;
  logic       instr_valid;
  logic       instr_ready;
  raw_instr_t instr;
  uint32      instr_pc;
  logic       redirect;
  logic [2:0] pc_sel;
  uint32      branch_target;
  uint32      jump_target;
  uint32      mtvec;
  uint32      mepc;
  logic       fetch_misaligned;
  uint32      misaligned_addr;

  modport master (
    output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
           fetch_misaligned, misaligned_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
           redirect, pc_sel, branch_target, jump_target, mtvec, mepc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
           fetch_misaligned, misaligned_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
           redirect, pc_sel, branch_target, jump_target, mtvec, mepc
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Synchronous word FIFO holding fetched instructions; head is shown combinationally.
// Push into a full FIFO is legal only together with a pop; clear empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [31:0]   data,
  output logic [CW-1:0] count,
  output logic [31:0]   head
);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          pop_ok, push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: issues word reads, buffers responses, delivers instructions to decode.
// Redirects flush the buffer and drop responses to requests issued before the redirect.
module instr_fetch
  import Common::*;
#(
  parameter uint32 RESET_PC = FETCH_RESET_PC,
  parameter int    DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state, state_nxt;
  uint32         fetch_pc, head_pc, target, mis_addr_q;
  logic [CW-1:0] outstanding, discard, count;
  logic [CW:0]   occupancy;
  raw_instr_t    head;
  logic          take, tgt_bad, running, req_fire, rsp_keep, push, pop, mis_q;

  always_comb begin
    take   = 1'b0;
    target = fetch_pc;
    case (pc_next_t'(bus.pc_sel))
      PC_BRANCH: begin take = bus.redirect; target = bus.branch_target; end
      PC_JUMP:   begin take = bus.redirect; target = bus.jump_target;   end
      PC_MTVEC:  begin take = bus.redirect; target = bus.mtvec;         end
      PC_MEPEC:  begin take = bus.redirect; target = bus.mepc;          end
      default:   ;
    endcase
  end

  assign tgt_bad   = word_misaligned(target);
  assign running   = (state == FETCH_RUN);
  assign occupancy = {1'b0, outstanding} + {1'b0, count};

  assign bus.mem_req_valid    = running && !bus.redirect && (occupancy < (CW+1)'(DEPTH));
  assign bus.mem_req_addr     = fetch_pc;
  assign bus.instr_valid      = running && !bus.redirect && (count != '0);
  assign bus.instr            = head;
  assign bus.instr_pc         = head_pc;
  assign bus.fetch_misaligned = mis_q;
  assign bus.misaligned_addr  = mis_addr_q;

  assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
  assign rsp_keep = bus.mem_rsp_valid && (discard == '0);
  assign push     = rsp_keep && !take;
  assign pop      = bus.instr_valid && bus.instr_ready;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (take),
    .data  (bus.mem_rsp_data),
    .count (count),
    .head  (head)
  );

  always_comb begin
    state_nxt = state;
    if (take) state_nxt = tgt_bad ? FETCH_MISALIGN : FETCH_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      mis_q       <= 1'b0;
      mis_addr_q  <= '0;
    end else if (take) begin
      fetch_pc    <= target;
      head_pc     <= target;
      outstanding <= '0;
      // Every request still in flight becomes stale, minus the one landing right now.
      discard     <= discard + outstanding - CW'(bus.mem_rsp_valid);
      mis_q       <= tgt_bad;
      if (tgt_bad) mis_addr_q <= target;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (pop)      head_pc  <= head_pc + 32'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
      if (bus.mem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
    end
  end

endmodule
